// File: rtl/av_bus_arbiter.sv
// Round-robin arbiter that puts NREQ bus masters in front of the AV I/O bridge s1 port.
// A grant is held for the whole cyc, and a per-access watchdog ends hung strobes with err.
module av_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_cyc_i,
  input  logic [NREQ-1:0]      req_stb_i,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [4*NREQ-1:0]    req_sel_i,
  input  logic [32*NREQ-1:0]   req_adr_i,
  input  logic [32*NREQ-1:0]   req_dat_i,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic [31:0]          req_dat_o,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic [31:0]          m_adr_o,
  output logic [31:0]          m_dat_o,
  input  logic                 m_ack_i,
  input  logic [31:0]          m_dat_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ERR     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic [IW-1:0]    last_reg;
  logic [WW-1:0]    wdog_reg;

  logic             is_busy;
  logic             is_err;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  own_cyc;
  logic [NREQ-1:0]  own_stb;
  logic [NREQ-1:0]  own_we;
  logic [3:0]       own_sel [NREQ];
  logic [31:0]      own_adr [NREQ];
  logic [31:0]      own_dat [NREQ];
  logic [3:0]       sel_or;
  logic [31:0]      adr_or;
  logic [31:0]      dat_or;
  logic             g_cyc;
  logic             g_stb;
  logic             g_we;
  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic             wdog_fire;

  assign is_busy = (state_reg == BUSY);
  assign is_err  = (state_reg == ERR);

  // Per-requester slices masked by the one-hot grant; OR-reduced below into the bridge mux.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign cand[gi]      = req_cyc_i[gi] & req_stb_i[gi];
      assign own_cyc[gi]   = gnt_reg[gi] & req_cyc_i[gi];
      assign own_stb[gi]   = gnt_reg[gi] & req_stb_i[gi];
      assign own_we[gi]    = gnt_reg[gi] & req_we_i[gi];
      assign own_sel[gi]   = gnt_reg[gi] ? req_sel_i[4*gi +: 4]   : 4'h0;
      assign own_adr[gi]   = gnt_reg[gi] ? req_adr_i[32*gi +: 32] : 32'h0;
      assign own_dat[gi]   = gnt_reg[gi] ? req_dat_i[32*gi +: 32] : 32'h0;
      assign req_ack_o[gi] = is_busy & gnt_reg[gi] & m_ack_i;
      assign req_err_o[gi] = is_err & gnt_reg[gi] & req_stb_i[gi];
    end
  endgenerate

  always_comb begin
    sel_or = '0;
    adr_or = '0;
    dat_or = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_or = sel_or | own_sel[i];
      adr_or = adr_or | own_adr[i];
      dat_or = dat_or | own_dat[i];
    end
  end

  assign g_cyc = |own_cyc;
  assign g_stb = |own_stb;
  assign g_we  = |own_we;

  // Rotating search starting just after the last owner; the first candidate wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_reg) + k) % NREQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign wdog_fire = WD_EN && g_stb && !m_ack_i && (wdog_reg == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      last_reg  <= IW'(NREQ - 1);
      wdog_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          wdog_reg <= '0;
          if (found) begin
            gnt_reg   <= NREQ'(1) << win;
            last_reg  <= win;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            gnt_reg   <= '0;
            wdog_reg  <= '0;
            state_reg <= RELEASE;
          end else if (wdog_fire) begin
            wdog_reg  <= '0;
            state_reg <= ERR;
          end else if (!g_stb || m_ack_i) begin
            wdog_reg <= '0;
          end else if (wdog_reg != '1) begin
            wdog_reg <= wdog_reg + WW'(1);
          end
        end
        ERR: begin
          // Hold the grant until the owner gives up its cycle.
          if (!g_cyc) begin
            gnt_reg   <= '0;
            state_reg <= RELEASE;
          end
        end
        default: begin
          gnt_reg   <= '0;
          wdog_reg  <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_reg;
  assign m_cyc_o   = is_busy & g_cyc;
  assign m_stb_o   = is_busy & g_stb;
  assign m_we_o    = is_busy & g_we;
  assign m_sel_o   = is_busy ? sel_or : 4'h0;
  assign m_adr_o   = is_busy ? adr_or : 32'h0;
  assign m_dat_o   = is_busy ? dat_or : 32'h0;
  assign req_dat_o = m_dat_i;

endmodule

// File: tb/tb_av_bus_arbiter.sv
// Bench for av_bus_arbiter: directed vector table, hand sequences for multi-cycle cases,
// then random traffic compared against a rule-level reference model.
module tb_av_bus_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [2:0]   req_cyc_i, req_stb_i, req_we_i;
  logic [11:0]  req_sel_i;
  logic [95:0]  req_adr_i, req_dat_i;
  logic [2:0]   req_ack_o, req_err_o, gnt_o;
  logic [31:0]  req_dat_o;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]   m_sel_o;
  logic [31:0]  m_adr_o, m_dat_o;
  logic         m_ack_i;
  logic [31:0]  m_dat_i;

  always #5 clk_i = ~clk_i;

  av_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
    .req_sel_i(req_sel_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
    .gnt_o(gnt_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner of the bus, error flag, release gap, last winner, stalled-strobe count.
  int   mo_owner, mo_last, mo_stall;
  bit   mo_err, mo_rel;
  logic [2:0]  e_gnt, e_ack, e_err;
  logic        e_cyc, e_stb, e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_dat;

  task automatic model_reset();
    mo_owner = -1; mo_err = 0; mo_rel = 0; mo_last = NREQ - 1; mo_stall = 0;
  endtask

  task automatic model_outputs();
    logic [2:0] cy, sb, wv;
    e_gnt = 0; e_ack = 0; e_err = 0; e_cyc = 0; e_stb = 0; e_we = 0;
    e_sel = 0; e_adr = 0; e_dat = 0;
    if (mo_owner >= 0) begin
      cy = req_cyc_i >> mo_owner;
      sb = req_stb_i >> mo_owner;
      wv = req_we_i >> mo_owner;
      e_gnt = 3'(1 << mo_owner);
      if (!mo_err) begin
        e_cyc = cy[0];
        e_stb = sb[0];
        e_we  = wv[0];
        e_sel = 4'(req_sel_i >> (4 * mo_owner));
        e_adr = 32'(req_adr_i >> (32 * mo_owner));
        e_dat = 32'(req_dat_i >> (32 * mo_owner));
        e_ack = m_ack_i ? e_gnt : 3'b000;
      end else begin
        e_err = sb[0] ? e_gnt : 3'b000;
      end
    end
  endtask

  task automatic model_step();
    logic [2:0] cy, sb;
    if (rst_i) begin
      model_reset();
    end else if (mo_rel) begin
      mo_rel = 0;
    end else if (mo_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int n;
        n = (mo_last + k) % NREQ;
        cy = req_cyc_i >> n;
        sb = req_stb_i >> n;
        if (cy[0] && sb[0]) begin
          mo_owner = n; mo_last = n; mo_stall = 0;
          break;
        end
      end
    end else begin
      cy = req_cyc_i >> mo_owner;
      sb = req_stb_i >> mo_owner;
      if (!cy[0]) begin
        mo_owner = -1; mo_err = 0; mo_rel = 1;
      end else if (!mo_err) begin
        if (sb[0] && !m_ack_i) begin
          mo_stall++;
          if (mo_stall == TIMEOUT) mo_err = 1;
        end else begin
          mo_stall = 0;
        end
      end
    end
  endtask

  task automatic model_compare();
    model_outputs();
    chk("rnd_gnt", gnt_o, e_gnt);
    chk("rnd_m_cyc", m_cyc_o, e_cyc);
    chk("rnd_m_stb", m_stb_o, e_stb);
    chk("rnd_m_we", m_we_o, e_we);
    chk("rnd_m_sel", m_sel_o, e_sel);
    chk("rnd_m_adr", m_adr_o, e_adr);
    chk("rnd_m_dat", m_dat_o, e_dat);
    chk("rnd_ack", req_ack_o, e_ack);
    chk("rnd_err", req_err_o, e_err);
    chk("rnd_rdat", req_dat_o, m_dat_i);
  endtask

  task automatic drv(input logic r, input logic [2:0] c, input logic [2:0] s,
                     input logic [2:0] w, input logic a, input logic [31:0] md);
    rst_i = r; req_cyc_i = c; req_stb_i = s; req_we_i = w; m_ack_i = a; m_dat_i = md;
    #1;
  endtask

  task automatic adv();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drv(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
    adv();
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        ack;
    logic [31:0] mdat;
    logic [2:0]  e_gnt;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic [2:0]  e_ack;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic [2:0] q, input logic a, input logic [31:0] md,
                              input logic [2:0] g, input logic c, input logic [31:0] ad,
                              input logic [2:0] ak);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.mdat = md;
    v.e_gnt = g; v.e_cyc = c; v.e_adr = ad; v.e_ack = ak;
    return v;
  endfunction

  initial begin
    logic [2:0] rc, rs;
    bit dead;

    // Single read by req0, then a reset.
    vq.push_back(mk(0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b001, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b001, 0, 32'h0,        3'b001, 1, 32'hFD000010, 3'b000));
    vq.push_back(mk(0, 3'b001, 1, 32'h12345678, 3'b001, 1, 32'hFD000010, 3'b001));
    vq.push_back(mk(0, 3'b000, 0, 32'h0,        3'b001, 0, 32'hFD000010, 3'b000));
    vq.push_back(mk(0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    // All three requesting: order 0,1,2,0 with a release gap between tenures.
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 1, 32'hA0A0A0A0, 3'b001, 1, 32'hFD000010, 3'b001));
    vq.push_back(mk(0, 3'b110, 0, 32'h0,        3'b001, 0, 32'hFD000010, 3'b000));
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 1, 32'hA1A1A1A1, 3'b010, 1, 32'hFD000110, 3'b010));
    vq.push_back(mk(0, 3'b101, 0, 32'h0,        3'b010, 0, 32'hFD000110, 3'b000));
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 1, 32'hA2A2A2A2, 3'b100, 1, 32'hFD000210, 3'b100));
    vq.push_back(mk(0, 3'b011, 0, 32'h0,        3'b100, 0, 32'hFD000210, 3'b000));
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b111, 1, 32'hB0B0B0B0, 3'b001, 1, 32'hFD000010, 3'b001));
    // Cyc drops together with ack: one ack, then release, no second ack.
    vq.push_back(mk(0, 3'b110, 1, 32'hC0C0C0C0, 3'b001, 0, 32'hFD000010, 3'b001));
    vq.push_back(mk(0, 3'b000, 1, 32'h0,        3'b000, 0, 32'h0,        3'b000));
    vq.push_back(mk(0, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0,        3'b000));

    req_sel_i = 12'hFFF;
    req_adr_i = {32'hFD000210, 32'hFD000110, 32'hFD000010};
    req_dat_i = {32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    model_reset();
    drv(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
    @(posedge clk_i);
    #1;
    adv();

    foreach (vq[i]) begin
      drv(vq[i].rst, vq[i].req, vq[i].req, 3'b000, vq[i].ack, vq[i].mdat);
      chk("vec_gnt", gnt_o, vq[i].e_gnt);
      chk("vec_m_cyc", m_cyc_o, vq[i].e_cyc);
      chk("vec_m_stb", m_stb_o, vq[i].e_cyc);
      chk("vec_m_adr", m_adr_o, vq[i].e_adr);
      chk("vec_ack", req_ack_o, vq[i].e_ack);
      chk("vec_err", req_err_o, 3'b000);
      chk("vec_rdat", req_dat_o, vq[i].mdat);
      $display("vec %0d: req=%b ack_in=%b gnt=%b m_cyc=%b req_ack=%b", i, vq[i].req,
               vq[i].ack, gnt_o, m_cyc_o, req_ack_o);
      adv();
    end

    // req1 read-modify-write while req0 waits.
    do_reset();
    drv(0, 3'b010, 3'b010, 3'b000, 0, 32'h0);      chk("rmw_idle_gnt", gnt_o, 3'b000); adv();
    drv(0, 3'b011, 3'b011, 3'b000, 1, 32'h5555AAAA);
    chk("rmw_rd_gnt", gnt_o, 3'b010); chk("rmw_rd_ack", req_ack_o, 3'b010);
    chk("rmw_rd_we", m_we_o, 1'b0); chk("rmw_rd_dat", req_dat_o, 32'h5555AAAA); adv();
    drv(0, 3'b011, 3'b001, 3'b000, 0, 32'h0);
    chk("rmw_gap_gnt", gnt_o, 3'b010); chk("rmw_gap_cyc", m_cyc_o, 1'b1);
    chk("rmw_gap_stb", m_stb_o, 1'b0); adv();
    drv(0, 3'b011, 3'b011, 3'b010, 1, 32'h0);
    chk("rmw_wr_gnt", gnt_o, 3'b010); chk("rmw_wr_we", m_we_o, 1'b1);
    chk("rmw_wr_ack", req_ack_o, 3'b010); chk("rmw_wr_dat", m_dat_o, 32'hD1D1D1D1); adv();
    drv(0, 3'b001, 3'b001, 3'b000, 0, 32'h0);
    chk("rmw_drop_gnt", gnt_o, 3'b010); chk("rmw_drop_cyc", m_cyc_o, 1'b0); adv();
    chk("rmw_rel_gnt", gnt_o, 3'b000); adv();
    chk("rmw_idle2_gnt", gnt_o, 3'b000); adv();
    chk("rmw_req0_gnt", gnt_o, 3'b001); chk("rmw_req0_adr", m_adr_o, 32'hFD000010);
    $display("seq rmw: req1 held grant across two strobes, req0 granted after release");
    drv(0, 3'b000, 3'b000, 3'b000, 0, 32'h0); adv(); adv();

    // Watchdog: bridge never acks req2.
    do_reset();
    drv(0, 3'b100, 3'b100, 3'b000, 0, 32'h0); adv();
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("wd_busy_cyc", m_cyc_o, 1'b1); chk("wd_busy_err", req_err_o, 3'b000); adv();
    end
    chk("wd_err", req_err_o, 3'b100); chk("wd_err_cyc", m_cyc_o, 1'b0);
    chk("wd_err_gnt", gnt_o, 3'b100); adv();
    chk("wd_err_hold", req_err_o, 3'b100); adv();
    drv(0, 3'b000, 3'b000, 3'b000, 0, 32'h0);
    chk("wd_drop_err", req_err_o, 3'b000); chk("wd_drop_gnt", gnt_o, 3'b100); adv();
    chk("wd_rel_gnt", gnt_o, 3'b000); chk("wd_rel_cyc", m_cyc_o, 1'b0); adv();
    $display("seq watchdog: err after %0d stalled strobes, released after cyc drop", TIMEOUT);

    // Reset in the middle of a tenure.
    do_reset();
    drv(0, 3'b010, 3'b010, 3'b000, 0, 32'h0); adv();
    chk("rst_busy_gnt", gnt_o, 3'b010); chk("rst_busy_cyc", m_cyc_o, 1'b1);
    drv(1, 3'b010, 3'b010, 3'b000, 0, 32'h0); adv();
    drv(0, 3'b111, 3'b111, 3'b000, 1, 32'h0);
    chk("rst_gnt", gnt_o, 3'b000); chk("rst_cyc", m_cyc_o, 1'b0);
    chk("rst_ack", req_ack_o, 3'b000); chk("rst_err", req_err_o, 3'b000); adv();
    drv(0, 3'b111, 3'b111, 3'b000, 0, 32'h0);
    chk("rst_first_gnt", gnt_o, 3'b001); adv();
    $display("seq reset: tenure dropped, first grant after reset to req0");
    drv(0, 3'b000, 3'b000, 3'b000, 0, 32'h0); adv(); adv();

    // Random traffic against the reference model.
    rc = 0; dead = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) dead = !dead;
      for (int n = 0; n < NREQ; n++) begin
        if ($urandom_range(0, 11) == 0) rc[n] = !rc[n];
        rs[n] = rc[n] & (dead || ($urandom_range(0, 3) != 0));
      end
      req_sel_i = 12'($urandom);
      req_adr_i = {$urandom, $urandom, $urandom};
      req_dat_i = {$urandom, $urandom, $urandom};
      drv(($urandom_range(0, 249) == 0), rc, rs, 3'($urandom),
          dead ? 1'b0 : 1'($urandom_range(0, 1)), $urandom);
      model_compare();
      adv();
    end
    $display("random: 3000 cycles compared against reference model");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
